// File: rtl/uart_pkg.sv
// uart_pkg: constants and FSM encoding shared by the UART transmitter and receiver.
// Contents: UART_OVERSAMPLE (sample pulses per serial bit), tx_state_e (transmit FSM states).
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts sample pulses and flags the pulse that completes one serial bit.
// Ports: clk_i clock, rst_ni sync active-low reset, clear_i holds the count at zero,
//        pulse_i oversample strobe, bit_done_o high on the OVERSAMPLE-th pulse of a bit.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic pulse_i,
    output logic bit_done_o
);

    localparam int W = $clog2(OVERSAMPLE);
    localparam logic [W-1:0] LAST = W'(OVERSAMPLE - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign bit_done_o = pulse_i && !clear_i && cnt_q == LAST;

    // Wrapping on bit_done restarts the count for the next state's bit.
    always_comb cnt_d = (clear_i || bit_done_o) ? '0 : pulse_i ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register, LSB-first serialiser,
// optional parity and oversampled bit timing shared with uart_rx.
// Ports: ACLK/ARESETn clock and sync active-low reset; tx_sample_pulse oversample strobe;
//        data_bits/parity_en/parity_odd0_even1 frame format (latched per frame);
//        tx_data_reg_wr/tx_data holding-register write; UART_TX serial line (idle high);
//        tx_ready holding register empty; tx_busy frame in progress; overflow dropped-write pulse.
// Build option: define UART_TX_TWO_STOP_EN to add the stop_bits2 input and a second stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic       tx_sample_pulse,
    input  logic       data_bits,
    input  logic       parity_en,
    input  logic       parity_odd0_even1,
`ifdef UART_TX_TWO_STOP_EN
    input  logic       stop_bits2,
`endif
    input  logic       tx_data_reg_wr,
    input  logic [7:0] tx_data,
    output logic       UART_TX,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       overflow
);

    tx_state_e  state_q;
    logic [7:0] hold_q, hold_d, shift_q;
    logic       hold_full_q, hold_full_d;
    logic       ovf_q, ovf_d;
    logic [2:0] bit_cnt_q;
    logic       dbits8_q, par_en_q, par_q, tx_q;
    logic       bit_done, two_stop, frame_end, load, wr_accept;

`ifdef UART_TX_TWO_STOP_EN
    logic stop2_q;
    assign two_stop = stop2_q;
`else
    assign two_stop = 1'b0;
`endif

    assign frame_end = bit_done && ((state_q == STOP && !two_stop) || state_q == STOP2);
    // Loading straight out of the last stop bit gives gap-free back-to-back frames.
    assign load      = hold_full_q && (state_q == IDLE || frame_end);

    always_comb begin
        wr_accept   = tx_data_reg_wr && (!hold_full_q || load);
        ovf_d       = tx_data_reg_wr && hold_full_q && !load;
        hold_full_d = wr_accept || (hold_full_q && !load);
        hold_d      = wr_accept ? tx_data : hold_q;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            hold_full_q <= 1'b0;
            hold_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
            ovf_q       <= ovf_d;
        end
    end

    uart_tx_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk_i      (ACLK),
        .rst_ni     (ARESETn),
        .clear_i    (state_q == IDLE),
        .pulse_i    (tx_sample_pulse),
        .bit_done_o (bit_done)
    );

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dbits8_q  <= 1'b1;
            par_en_q  <= 1'b0;
            par_q     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= 1'b0;
`endif
        end else if (load) begin
            state_q   <= START;
            tx_q      <= 1'b0;
            shift_q   <= hold_q;
            bit_cnt_q <= '0;
            dbits8_q  <= data_bits;
            par_en_q  <= parity_en;
            // Parity is fixed at load; bit 7 is masked off in 7-bit mode.
            par_q     <= ^(hold_q & {data_bits, 7'h7f}) ^ ~parity_odd0_even1;
`ifdef UART_TX_TWO_STOP_EN
            stop2_q   <= stop_bits2;
`endif
        end else if (bit_done) begin
            case (state_q)
                START: begin
                    state_q <= DATA;
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                end
                DATA: begin
                    // Last data bit index is 6 or 7 depending on the latched width.
                    if (bit_cnt_q == {2'b11, dbits8_q}) begin
                        state_q <= par_en_q ? PARITY : STOP;
                        tx_q    <= par_en_q ? par_q : 1'b1;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                PARITY: begin
                    state_q <= STOP;
                    tx_q    <= 1'b1;
                end
                STOP: begin
                    state_q <= two_stop ? STOP2 : IDLE;
                    tx_q    <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign UART_TX  = tx_q;
    assign tx_ready = !hold_full_q;
    assign tx_busy  = state_q != IDLE;
    assign overflow = ovf_q;

endmodule
